// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte-stream blocks.
package uart_pkg;

  localparam int UART_BYTE_WIDTH = 8;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin pick: the first set request at or after the pointer, wrapping.
module round_robin_select #(
  parameter int NUM_REQUESTERS = 2,
  parameter int PW             = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic [PW-1:0]             ptr_i,
  output logic [NUM_REQUESTERS-1:0] winner_o,
  output logic                      any_o
);

  logic found;

  // First pass covers indices at or after the pointer, second pass the wrapped-around ones.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && req_i[i] && (PW'(i) >= ptr_i)) begin
        winner_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && req_i[i] && (PW'(i) < ptr_i)) begin
        winner_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART transmitter from several byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS    = 2,
  parameter int MAX_MESSAGE_BYTES = 64,
  localparam int PW = $clog2(NUM_REQUESTERS),
  localparam int CW = $clog2(MAX_MESSAGE_BYTES + 1)
) (
  input  logic                                      clock_i,
  input  logic                                      reset_ni,
  input  logic [NUM_REQUESTERS-1:0]                 request_valid_i,
  input  logic [UART_BYTE_WIDTH*NUM_REQUESTERS-1:0] request_data_i,
  input  logic [NUM_REQUESTERS-1:0]                 request_last_i,
  output logic [NUM_REQUESTERS-1:0]                 request_ready_o,
  output logic                                      tx_valid_o,
  output logic [UART_BYTE_WIDTH-1:0]                tx_data_o,
  input  logic                                      tx_ready_i,
  output logic [NUM_REQUESTERS-1:0]                 grant_o,
  output logic                                      message_overflow_o,
  output arb_state_e                                dbg_state_o,
  output logic [PW-1:0]                             dbg_pointer_o,
  output logic [CW-1:0]                             dbg_count_o
);

  // Handshake: a byte moves on a rising edge where valid && ready; once valid is
  // raised, data/last hold until that edge, and ready never waits on valid.

  arb_state_e                 state_q, state_d;
  logic [NUM_REQUESTERS-1:0]  grant_q, grant_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [UART_BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                       ovf_q, ovf_d;

  logic [NUM_REQUESTERS-1:0]  rr_winner;
  logic                       rr_any;
  logic                       out_free;
  logic                       sel_valid;
  logic                       sel_last;
  logic [UART_BYTE_WIDTH-1:0] sel_data;
  logic [PW-1:0]              grant_idx;
  logic [PW-1:0]              next_ptr;
  logic                       beat;
  logic                       at_limit;

  round_robin_select #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .PW            (PW)
  ) u_select (
    .req_i   (request_valid_i),
    .ptr_i   (ptr_q),
    .winner_o(rr_winner),
    .any_o   (rr_any)
  );

  assign out_free        = !tx_valid_q || tx_ready_i;
  assign request_ready_o = (state_q == ARB_GRANTED && out_free) ? grant_q : '0;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_q[i]) begin
        sel_valid = sel_valid | request_valid_i[i];
        sel_last  = sel_last | request_last_i[i];
        sel_data  = sel_data | request_data_i[UART_BYTE_WIDTH*i +: UART_BYTE_WIDTH];
        grant_idx = PW'(i);
      end
    end
  end

  assign next_ptr = (grant_idx == PW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + PW'(1);
  assign beat     = (state_q == ARB_GRANTED) && out_free && sel_valid;
  assign at_limit = (cnt_q == CW'(MAX_MESSAGE_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    ovf_d      = ovf_q;

    // Loading wins over draining, so a same-cycle drain and load keeps exactly one byte.
    if (beat) begin
      tx_valid_d = 1'b1;
      tx_data_d  = sel_data;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (rr_any) begin
          grant_d = rr_winner;
          state_d = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        if (beat) begin
          if (sel_last || at_limit) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            cnt_d   = '0;
            ptr_d   = next_ptr;
            if (!sel_last) begin
              ovf_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_valid_o         = tx_valid_q;
  assign tx_data_o          = tx_data_q;
  assign grant_o            = grant_q;
  assign message_overflow_o = ovf_q;
  assign dbg_state_o        = state_q;
  assign dbg_pointer_o      = ptr_q;
  assign dbg_count_o        = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 64-byte-limit instance for the main traffic, a 4-byte one for overflow.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic        tx_ready;

  logic [1:0] a_ready, a_grant, b_ready, b_grant;
  logic       a_tx_valid, a_ovf, b_tx_valid, b_ovf;
  logic [7:0] a_tx_data, b_tx_data;
  arb_state_e a_state, b_state;
  logic [0:0] a_ptr, b_ptr;
  logic [6:0] a_cnt;
  logic [2:0] b_cnt;

  uart_tx_arbiter #(.NUM_REQUESTERS(2), .MAX_MESSAGE_BYTES(64)) dut_a (
    .clock_i(clk), .reset_ni(rst_a_n),
    .request_valid_i(req_valid), .request_data_i(req_data), .request_last_i(req_last),
    .request_ready_o(a_ready), .tx_valid_o(a_tx_valid), .tx_data_o(a_tx_data),
    .tx_ready_i(tx_ready), .grant_o(a_grant), .message_overflow_o(a_ovf),
    .dbg_state_o(a_state), .dbg_pointer_o(a_ptr), .dbg_count_o(a_cnt)
  );

  uart_tx_arbiter #(.NUM_REQUESTERS(2), .MAX_MESSAGE_BYTES(4)) dut_b (
    .clock_i(clk), .reset_ni(rst_b_n),
    .request_valid_i(req_valid), .request_data_i(req_data), .request_last_i(req_last),
    .request_ready_o(b_ready), .tx_valid_o(b_tx_valid), .tx_data_o(b_tx_data),
    .tx_ready_i(tx_ready), .grant_o(b_grant), .message_overflow_o(b_ovf),
    .dbg_state_o(b_state), .dbg_pointer_o(b_ptr), .dbg_count_o(b_cnt)
  );

  // View of whichever instance the current test is driving.
  logic       sel_b;
  logic [1:0] v_ready, v_grant;
  logic       v_tx_valid;
  logic [7:0] v_tx_data;
  always_comb begin
    v_ready    = sel_b ? b_ready    : a_ready;
    v_grant    = sel_b ? b_grant    : a_grant;
    v_tx_valid = sel_b ? b_tx_valid : a_tx_valid;
    v_tx_data  = sel_b ? b_tx_data  : a_tx_data;
  end

  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs(input int cyc, input int start0, input int bp);
    req_valid[0]   = (cyc >= start0) && (src_q0.size() > 0);
    req_data[7:0]  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
    req_last[0]    = (src_q0.size() > 0) ? src_q0[0][8] : 1'b0;
    req_valid[1]   = (src_q1.size() > 0);
    req_data[15:8] = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
    req_last[1]    = (src_q1.size() > 0) ? src_q1[0][8] : 1'b0;
    tx_ready       = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
  endtask

  // Drives both source queues and checks every output byte against exp_q.
  task automatic run(input int max_cyc, input int start0, input int bp, input int stop_out);
    int         cyc;
    int         outs;
    logic       fire0, fire1, hold_pend;
    logic [7:0] hold_data;
    bit         done;
    cyc = 0; outs = 0; hold_pend = 1'b0; hold_data = '0; done = 1'b0;
    while (!done) begin
      drive_inputs(cyc, start0, bp);
      @(negedge clk);
      if (hold_pend) begin
        check_eq("hold_valid", 32'(v_tx_valid), 32'd1);
        check_eq("hold_data", 32'(v_tx_data), 32'(hold_data));
      end
      hold_pend = v_tx_valid && !tx_ready;
      hold_data = v_tx_data;
      check_eq("ready_owner", 32'(v_ready & ~v_grant), 32'd0);
      fire0 = req_valid[0] && v_ready[0];
      fire1 = req_valid[1] && v_ready[1];
      if (v_tx_valid && tx_ready) begin
        outs++;
        if (exp_q.size() == 0) check_eq("extra_byte", {23'd0, 1'b1, v_tx_data}, 32'd0);
        else                   check_eq("tx_data", 32'(v_tx_data), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (fire0) src_q0.delete(0);
      if (fire1) src_q1.delete(0);
      cyc++;
      if (stop_out > 0) done = (outs >= stop_out);
      else done = (src_q0.size() == 0) && (src_q1.size() == 0) && (exp_q.size() == 0) && !v_tx_valid;
      if (!done && cyc >= max_cyc) begin
        check_eq("run_timeout", 32'(src_q0.size() + src_q1.size() + exp_q.size()), 32'd0);
        done = 1'b1;
      end
    end
    drive_inputs(cyc, start0, bp);
  endtask

  task automatic reset_a();
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    rst_a_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_a_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_b();
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; sel_b = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;

    // Idle after reset.
    reset_a();
    check_eq("rst_state", 32'(a_state), 32'(ARB_IDLE));
    check_eq("rst_ptr", 32'(a_ptr), 32'd0);
    check_eq("rst_cnt", 32'(a_cnt), 32'd0);
    check_eq("rst_ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_grant", 32'(a_grant), 32'd0);
      check_eq("idle_tx_valid", 32'(a_tx_valid), 32'd0);
      check_eq("idle_ready", 32'(a_ready), 32'd0);
    end

    // Single requester.
    src_q0.push_back({1'b0, 8'h41}); src_q0.push_back({1'b0, 8'h42}); src_q0.push_back({1'b1, 8'h43});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    run(100, 0, 0, 0);
    check_eq("single_grant", 32'(a_grant), 32'd0);
    check_eq("single_ptr", 32'(a_ptr), 32'd1);
    check_eq("single_state", 32'(a_state), 32'(ARB_IDLE));

    // Contention: whole messages alternate.
    reset_a();
    for (int m = 0; m < 3; m++) begin
      src_q0.push_back({1'b0, 8'h10}); src_q0.push_back({1'b1, 8'h11});
      src_q1.push_back({1'b0, 8'h20}); src_q1.push_back({1'b1, 8'h21});
      exp_q.push_back(8'h10); exp_q.push_back(8'h11);
      exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    end
    run(300, 0, 0, 0);
    check_eq("rr_ptr", 32'(a_ptr), 32'd0);

    // Backpressure with a 1-in-3 ready duty.
    for (int b = 0; b < 5; b++) begin
      src_q0.push_back({(b == 4), 8'(8'h50 + b)});
      exp_q.push_back(8'(8'h50 + b));
    end
    run(300, 0, 1, 0);
    check_eq("bp_grant", 32'(a_grant), 32'd0);

    // Reset in the middle of a message.
    reset_a();
    for (int b = 0; b < 5; b++) src_q0.push_back({(b == 4), 8'(8'h41 + b)});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    run(100, 0, 0, 2);
    check_eq("pre_rst_valid", 32'(a_tx_valid), 32'd1);
    rst_a_n = 1'b0;
    #1;
    check_eq("async_tx_valid", 32'(a_tx_valid), 32'd0);
    check_eq("async_grant", 32'(a_grant), 32'd0);
    check_eq("async_ready", 32'(a_ready), 32'd0);
    src_q0.delete();
    req_valid = '0;
    @(negedge clk) rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_state", 32'(a_state), 32'(ARB_IDLE));
    check_eq("post_rst_cnt", 32'(a_cnt), 32'd0);
    src_q0.push_back({1'b0, 8'h51}); src_q0.push_back({1'b1, 8'h52});
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    run(100, 0, 0, 0);

    // Overflow on the 4-byte-limit instance; req0 shows up mid-message.
    rst_a_n = 1'b0;
    sel_b = 1'b1;
    reset_b();
    check_eq("b_rst_ovf", 32'(b_ovf), 32'd0);
    for (int b = 0; b < 6; b++) src_q1.push_back({1'b0, 8'(8'h60 + b)});
    src_q0.push_back({1'b0, 8'h70}); src_q0.push_back({1'b1, 8'h71});
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h60 + b));
    exp_q.push_back(8'h70); exp_q.push_back(8'h71);
    exp_q.push_back(8'h64); exp_q.push_back(8'h65);
    run(200, 2, 0, 0);
    check_eq("ovf_flag", 32'(b_ovf), 32'd1);
    check_eq("ovf_grant_held", 32'(b_grant), 32'd2);
    check_eq("ovf_cnt", 32'(b_cnt), 32'd2);
    check_eq("ovf_state", 32'(b_state), 32'(ARB_GRANTED));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
